// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: buffers two image rows, tracks a
// 3x3 shift register of pixel columns, and emits every valid (unpadded,
// stride-1) window as a packed word with a valid/ready handshake.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [9*DATA_W-1:0]   ifmap_window,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       col_reg;
  logic [RW-1:0]       row_reg;
  logic                win_valid_reg;
  logic [9*DATA_W-1:0] ifmap_window_reg;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2, indexed by column.
  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   lb0_rd, lb1_rd;

  // Window shift register indexed [column][row]; column 0 is the leftmost.
  logic [DATA_W-1:0]   win_reg  [3][3];
  logic [DATA_W-1:0]   win_next [3][3];
  logic [9*DATA_W-1:0] win_flat_next;

  logic accept, transfer, emit, last_col, last_row;

  assign accept   = pix_valid && pix_ready;
  assign transfer = win_valid_reg && win_ready;
  assign last_col = (col_reg == COL_LAST);
  assign last_row = (row_reg == ROW_LAST);
  assign emit     = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
  assign lb0_rd   = lb0[col_reg];
  assign lb1_rd   = lb1[col_reg];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: the last pixel ends RUN, DRAIN waits for the final window to leave.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_col && last_row) state_next = DRAIN;
      DRAIN:   if (!win_valid_reg || win_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; input is throttled while a window is held.
  always_comb begin
    pix_ready  = (state_reg == RUN) && (!win_valid_reg || win_ready);
    busy       = (state_reg != IDLE);
    frame_done = (state_reg == DONE);
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_reg <= '0;
        row_reg <= last_row ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  // Line buffers shift one row down per accepted pixel; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_reg] <= lb0_rd;
      lb0[col_reg] <= pix_in;
    end
  end

  // Window shift: columns move left, new right column is {row r-2, row r-1, row r}.
  always_comb begin
    win_next = win_reg;
    if (accept) begin
      win_next[0] = win_reg[1];
      win_next[1] = win_reg[2];
      win_next[2][0] = lb1_rd;
      win_next[2][1] = lb0_rd;
      win_next[2][2] = pix_in;
    end
  end

  // Pack element (row, col) at slot 3*row+col so the newest pixel lands in the top byte.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_pack
      assign win_flat_next[DATA_W*gi +: DATA_W] = win_next[gi % 3][gi / 3];
    end
  endgenerate

  // Shift register state; history across row wrap is harmless since col>=2 gates emission.
  always_ff @(posedge clk) begin
    win_reg <= win_next;
  end

  // Output window register: load on a window-producing accept, clear valid on a bare transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_window_reg <= '0;
      win_valid_reg    <= 1'b0;
    end else if (emit) begin
      ifmap_window_reg <= win_flat_next;
      win_valid_reg    <= 1'b1;
    end else if (transfer) begin
      win_valid_reg    <= 1'b0;
    end
  end

  assign ifmap_window = ifmap_window_reg;
  assign win_valid    = win_valid_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 instance for the handshake/control tests
// and a default 8x8 instance for the full-size frame, with a scoreboard of
// expected windows built from an image model.
module tb_conv_window_gen;

  logic        clk;
  logic        rst4, rst8;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        win_ready;
  logic        sel;

  logic        pr4, wv4, busy4, fd4;
  logic [71:0] win4;
  logic        pr8, wv8, busy8, fd8;
  logic [71:0] win8;

  logic        pix_ready_m, win_valid_m, busy_m, frame_done_m;
  logic [71:0] window_m;

  conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr4), .ifmap_window(win4), .win_valid(wv4), .win_ready(win_ready),
    .busy(busy4), .frame_done(fd4)
  );

  conv_window_gen dut8 (
    .clk(clk), .rst(rst8), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr8), .ifmap_window(win8), .win_valid(wv8), .win_ready(win_ready),
    .busy(busy8), .frame_done(fd8)
  );

  assign pix_ready_m  = sel ? pr8   : pr4;
  assign win_valid_m  = sel ? wv8   : wv4;
  assign busy_m       = sel ? busy8 : busy4;
  assign frame_done_m = sel ? fd8   : fd4;
  assign window_m     = sel ? win8  : win4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_win = 0;
  int n_fd  = 0;
  int img [8][8];
  logic [71:0] exp_q [$];
  logic [71:0] got_q [$];

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Expected window whose bottom-right pixel is (r,c), built from the image model.
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(img[r-2+i][c-2+j]);
    return w;
  endfunction

  // Scoreboard consumer: every transferred window is popped and compared.
  always @(negedge clk) begin
    if (win_valid_m && win_ready) begin
      n_win++;
      got_q.push_back(window_m);
      check_eq("win_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check_eq("window", window_m, e);
        $display("window %0d: %h", n_win, window_m);
      end
    end
    if (frame_done_m) n_fd++;
  end

  task automatic send_pix(input int v, input int r, input int c);
    bit acc;
    int guard;
    pix_in = 8'(v);
    pix_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = pix_ready_m;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("pix_accept", 72'(acc), 72'd1);
    if (acc) begin
      img[r][c] = v;
      if (r >= 2 && c >= 2) exp_q.push_back(model_win(r, c));
    end
  endtask

  task automatic stream_frame(input int w, input int h, input bit gaps);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) begin
          pix_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        send_pix((r * w + c) % 256, r, c);
      end
    pix_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input int exp_w, input int w0, input int f0);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_m && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("busy_end", 72'(busy_m), 72'd0);
    check_eq("win_count", 72'(n_win - w0), 72'(exp_w));
    check_eq("frame_done_count", 72'(n_fd - f0), 72'd1);
    check_eq("sb_empty", 72'(exp_q.size()), 72'd0);
    exp_q.delete();
  endtask

  // Holds win_ready low for five cycles once the first window shows up.
  task automatic ready_ctrl();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!win_valid_m && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("first_win_seen", 72'(win_valid_m), 72'd1);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      check_eq("hold_pix_ready", 72'(pix_ready_m), 72'd0);
      check_eq("hold_window", window_m, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
  endtask

  initial begin
    int w0, f0;
    rst4 = 1'b1; rst8 = 1'b1; start = 1'b0; pix_in = '0;
    pix_valid = 1'b0; win_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_pix_ready", 72'(pix_ready_m), 72'd0);
    check_eq("rst_win_valid", 72'(win_valid_m), 72'd0);
    check_eq("rst_busy", 72'(busy_m), 72'd0);
    check_eq("rst_frame_done", 72'(frame_done_m), 72'd0);
    check_eq("rst_window", window_m, 72'd0);
    @(posedge clk);
    #1;

    // Test 1: back-to-back stream, win_ready always high
    w0 = n_win; f0 = n_fd; got_q.delete();
    pulse_start();
    stream_frame(4, 4, 1'b0);
    finish_frame(4, w0, f0);
    if (got_q.size() >= 4) begin
      check_eq("t1_first", got_q[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check_eq("t1_last", got_q[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    end

    // Test 2: downstream stall after the first window
    w0 = n_win; f0 = n_fd;
    win_ready = 1'b0;
    pulse_start();
    fork
      stream_frame(4, 4, 1'b0);
      ready_ctrl();
    join
    win_ready = 1'b1;
    finish_frame(4, w0, f0);

    // Test 3: random input gaps
    w0 = n_win; f0 = n_fd;
    pulse_start();
    stream_frame(4, 4, 1'b1);
    finish_frame(4, w0, f0);

    // Test 4: reset mid-frame, then a fresh frame
    f0 = n_fd;
    pulse_start();
    for (int i = 0; i < 10; i++) send_pix(i, i / 4, i % 4);
    pix_valid = 1'b0;
    rst4 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_mid_win_valid", 72'(win_valid_m), 72'd0);
      check_eq("rst_mid_frame_done", 72'(frame_done_m), 72'd0);
    end
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    check_eq("abort_no_done", 72'(n_fd - f0), 72'd0);
    exp_q.delete();
    w0 = n_win; f0 = n_fd;
    pulse_start();
    stream_frame(4, 4, 1'b0);
    finish_frame(4, w0, f0);

    // Test 5: pix_valid in IDLE is refused; start held through RUN is ignored
    pix_in = 8'hAA;
    pix_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_pix_ready", 72'(pix_ready_m), 72'd0);
      check_eq("idle_busy", 72'(busy_m), 72'd0);
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    w0 = n_win; f0 = n_fd;
    start = 1'b1;
    @(posedge clk);
    #1;
    stream_frame(4, 4, 1'b0);
    start = 1'b0;
    finish_frame(4, w0, f0);
    repeat (3) begin
      @(negedge clk);
      check_eq("post_frame_idle", 72'(busy_m), 72'd0);
    end

    // Test 6: default 8x8 instance
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    sel = 1'b1;
    rst8 = 1'b0;
    @(posedge clk);
    #1;
    w0 = n_win; f0 = n_fd;
    pulse_start();
    stream_frame(8, 8, 1'b0);
    finish_frame(36, w0, f0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution top-level. It accepts one 8-bit ifmap pixel per cycle in raster order. It buffers two image rows in line buffers and emits each valid (no padding, stride 1) 3x3 window as a packed 72-bit word. This word matches the ifmap_in format of the convolution stage. A valid/ready handshake is used on both sides, and start/frame_done provide per-frame control.

Parameters:
DATA_W, 8, bits per pixel (window width is 9*DATA_W)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new frame; sampled only in IDLE
pix_in  input  DATA_W  input pixel, raster order
pix_valid  input  1  pix_in valid
pix_ready  output  1  block accepts pix_in this cycle
ifmap_window  output  9*DATA_W  packed 3x3 window
win_valid  output  1  ifmap_window valid
win_ready  input  1  downstream consumes window
busy  output  1  frame in progress (not IDLE)
frame_done  output  1  one-cycle pulse after the last window of the frame is consumed

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, row/col counters=0, win_valid=0, ifmap_window=0, pix_ready=0, busy=0, frame_done=0. Line-buffer contents are don't-care. Reset mid-frame aborts the frame with no frame_done.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: pix_ready=0. When start=1: clear row/col, next state RUN. start is ignored in all other states.
  - RUN: pix_ready = !win_valid || win_ready.
    - A pixel is accepted when pix_valid && pix_ready.
    - On accept, col increments. When col wraps at IMG_W-1, col returns to 0 and row increments.
    - Accepting pixel (IMG_H-1, IMG_W-1) moves the block to DRAIN.
  - DRAIN: pix_ready=0. Stay in DRAIN until win_valid=0, or until win_valid && win_ready. Then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Line buffers: two IMG_W-deep buffers indexed by col.
  - On accept, read lb1[col] (row r-2) and lb0[col] (row r-1).
  - Then write lb1[col]<=lb0[col] and lb0[col]<=pix_in.
- Window shift register: 3x3. On accept, the left columns shift left and the new right column is {lb1[col], lb0[col], pix_in}.
  - Column history spans row boundaries. It is valid because windows are only emitted for col>=2.
- Packing: element (r,c) is at bits [DATA_W*(3r+c) +: DATA_W].
  - r=0 is the top (oldest) row; c=0 is the leftmost column.
  - So bits [7:0] hold the top-left element and bits [71:64] the bottom-right (the newest pixel).
- Emission: if the accepted pixel has row>=2 and col>=2, then on the next edge ifmap_window is loaded with the updated window and win_valid=1.
  - Latency is 1 cycle from accept.
  - ifmap_window and win_valid hold stable until win_ready=1.
- Handshake: a window transfers on win_valid && win_ready.
  - If a transfer and a new window-producing accept happen in the same cycle, win_valid stays 1 with the new data (no bubble).
  - If a transfer happens with no new window, win_valid goes to 0.
- Windows per frame = (IMG_W-2)*(IMG_H-2), in raster order of their bottom-right pixel.
- pix_valid=0 stalls: counters and buffers hold, and there is no output change except the handshake above.

Test Plan:
1. IMG_W=4, IMG_H=4, start pulse, pixels 0..15 streamed back-to-back with win_ready=1 -> exactly 4 windows.
   - First window appears 1 cycle after pixel 10 is accepted: bytes[0..8]=0,1,2,4,5,6,8,9,10.
   - Last window: 5,6,7,9,10,11,13,14,15.
   - frame_done pulses once; busy ends 0.
2. Same stream with win_ready=0 held for 5 cycles after the first window -> pix_ready=0 while the window is held, window stays 0,1,2,4,5,6,8,9,10, and no pixels are lost. The remaining 3 windows match the values in test 1.
3. Random pix_valid gaps (50% duty) with win_ready=1 -> windows identical to test 1, count=4.
4. Reset asserted after pixel 9 is accepted, then start and a fresh 0..15 frame -> win_valid=0 and frame_done=0 during reset. The new frame yields exactly the test 1 windows.
5. start held high during RUN, and pix_valid pulsed in IDLE -> start is ignored and no pixels are accepted in IDLE (pix_ready=0). Exactly one frame of 4 windows is produced.
6. Default IMG_W=8, IMG_H=8, pixels = index mod 256 -> 36 windows. Window k (bottom-right at row r, col c) has top-left element 8*(r-2)+(c-2). frame_done pulses exactly once.
